// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered flags, programmable thresholds,
// sticky overflow/underflow errors and a selectable registered or FWFT read port.
module sync_fifo_param #(
   parameter int  DATA_WIDTH  = 8,
   parameter int  FIFO_DEPTH  = 16,
   parameter int  FIFO_AFULL  = FIFO_DEPTH - 2,
   parameter int  FIFO_AEMPTY = 2,
   parameter bit  FWFT        = 1'b0,
   localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_param: FIFO_DEPTH must be a power of two and at least 4");
   end
   if ((FIFO_AFULL < 1) || (FIFO_AFULL > FIFO_DEPTH)) begin : g_bad_afull
      $error("sync_fifo_param: FIFO_AFULL out of range 1..FIFO_DEPTH");
   end
   if ((FIFO_AEMPTY < 0) || (FIFO_AEMPTY > FIFO_DEPTH - 1)) begin : g_bad_aempty
      $error("sync_fifo_param: FIFO_AEMPTY out of range 0..FIFO_DEPTH-1");
   end

   localparam logic [ADDR_WIDTH:0] DEPTH_L  = FIFO_DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AFULL_L  = FIFO_AFULL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AEMPTY_L = FIFO_AEMPTY[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ZERO_L   = '0;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_reg, rd_ptr_reg, level_reg, level_next;
   logic                  full_reg, empty_reg, afull_reg, aempty_reg;
   logic                  overflow_reg, underflow_reg;
   logic                  wr_vld, rd_vld;

   // Acceptance uses this cycle's registered flags; clr blocks both sides.
   assign wr_vld = wr_en & ~full_reg & ~clr;
   assign rd_vld = rd_en & ~empty_reg & ~clr;

   always_comb begin
      level_next = level_reg;
      if (clr) begin
         level_next = '0;
      end else begin
         level_next = level_reg + (ZERO_L | wr_vld) - (ZERO_L | rd_vld);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         afull_reg     <= 1'b0;
         aempty_reg    <= 1'b1;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg <= clr ? '0 : wr_ptr_reg + (ZERO_L | wr_vld);
         rd_ptr_reg <= clr ? '0 : rd_ptr_reg + (ZERO_L | rd_vld);
         level_reg  <= level_next;
         full_reg   <= (level_next == DEPTH_L);
         empty_reg  <= (level_next == ZERO_L);
         afull_reg  <= (level_next >= AFULL_L);
         aempty_reg <= (level_next <= AEMPTY_L);
         if (clr) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
         end else begin
            if (wr_en && full_reg)  overflow_reg  <= 1'b1;
            if (rd_en && empty_reg) underflow_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_vld) mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= wr_data;
   end

   if (FWFT) begin : g_fwft
      // Head word is shown whenever the FIFO holds data; zero while empty.
      assign rd_data  = empty_reg ? '0 : mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
      assign rd_valid = ~empty_reg;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
         end else begin
            rd_valid_reg <= rd_vld;
            if (rd_vld) rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
         end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
   end

   assign full      = full_reg;
   assign empty     = empty_reg;
   assign afull     = afull_reg;
   assign aempty    = aempty_reg;
   assign level     = level_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: one registered-read and one FWFT instance
// driven with identical stimulus and checked against a small level/flag model.
module tb_sync_fifo_param;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFULL = DEPTH - 2;
   localparam int AEMPT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          full0, empty0, afull0, aempty0, overflow0, underflow0;
   logic          full1, empty1, afull1, aempty1, overflow1, underflow1;
   logic [4:0]    level0, level1;

   int checks = 0;
   int errors = 0;

   int            m_level = 0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_AFULL(AFULL),
                     .FIFO_AEMPTY(AEMPT), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
      .empty(empty0), .afull(afull0), .aempty(aempty0), .level(level0),
      .overflow(overflow0), .underflow(underflow0));

   sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_AFULL(AFULL),
                     .FIFO_AEMPTY(AEMPT), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
      .empty(empty1), .afull(afull1), .aempty(aempty1), .level(level1),
      .overflow(overflow1), .underflow(underflow1));

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // {full, empty, afull, aempty, overflow, underflow, level}
   function automatic logic [10:0] exp_status();
      logic [4:0] lv;
      lv = m_level[4:0];
      return {m_level == DEPTH, m_level == 0, m_level >= AFULL, m_level <= AEMPT,
              m_ovf, m_udf, lv};
   endfunction

   function automatic logic [10:0] stat0();
      return {full0, empty0, afull0, aempty0, overflow0, underflow0, level0};
   endfunction

   function automatic logic [10:0] stat1();
      return {full1, empty1, afull1, aempty1, overflow1, underflow1, level1};
   endfunction

   task automatic model_reset();
      m_level = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_stat0"}, 32'(stat0()), 32'(exp_status()));
      check_eq({tag, "_stat1"}, 32'(stat1()), 32'(exp_status()));
      check_eq({tag, "_vld0"}, 32'(rd_valid0), 32'd0);
      check_eq({tag, "_data0"}, 32'(rd_data0), 32'd0);
      check_eq({tag, "_vld1"}, 32'(rd_valid1), 32'd0);
      check_eq({tag, "_data1"}, 32'(rd_data1), 32'd0);
   endtask

   // One clock cycle: drive, update model across the edge, compare everything.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      logic          wa, ra, was_full, was_empty;
      logic [DW-1:0] exp0;
      wr_en = w; wr_data = d; rd_en = r; clr = c;
      was_full  = (m_level == DEPTH);
      was_empty = (m_level == 0);
      wa = w & ~c & ~was_full;
      ra = r & ~c & ~was_empty;
      exp0 = '0;
      if (ra) void'(q1.pop_front());
      if (wa) begin
         q0.push_back(d);
         q1.push_back(d);
      end
      @(posedge clk);
      #1;
      if (ra) exp0 = q0.pop_front();
      if (c) begin
         m_level = 0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
         q0.delete();
         q1.delete();
      end else begin
         m_level = m_level + int'(wa) - int'(ra);
         m_ovf   = m_ovf | (w & was_full);
         m_udf   = m_udf | (r & was_empty);
      end
      check_eq("rd_valid0", 32'(rd_valid0), 32'(ra));
      if (ra) check_eq("rd_data0", 32'(rd_data0), 32'(exp0));
      check_eq("status0", 32'(stat0()), 32'(exp_status()));
      check_eq("status1", 32'(stat1()), 32'(exp_status()));
      check_eq("rd_valid1", 32'(rd_valid1), 32'(m_level != 0));
      if (q1.size() > 0) check_eq("rd_data1", 32'(rd_data1), 32'(q1[0]));
      $display("cyc w=%0b d=%02h r=%0b c=%0b lvl=%0d", w, d, r, c, m_level);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill: afull after 14th write, full after 16th.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      // Overflow alone, then write+read while full.
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      cyc(1'b1, 8'hBB, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // Single word, registered-read pulse, underflow.
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b1, 8'h77, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      // Level 8 steady state across pointer wraps.
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // FWFT word appears without rd_en.
      cyc(1'b1, 8'h33, 1'b0, 1'b0);
      check_eq("fwft_head", 32'(rd_data1), 32'h33);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Level 10 with overflow, clr beats a concurrent write.
      for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("async_rst");
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
